// File: rtl/sound_sequencer_if.sv
// Event/clip handshake between game logic and the sound sequencer, plus the
// clip selection type shared with the audio player.
package sound_pkg;
  typedef enum logic [2:0] {
    SOUND_GAME_PLAY = 3'd0,
    SOUND_LOADING   = 3'd1,
    SOUND_READY     = 3'd2,
    SOUND_FAIL      = 3'd3,
    SOUND_WIN       = 3'd4
  } sound_t;
endpackage

interface sound_if;
  logic              evt_intro;
  logic              evt_ready;
  logic              evt_chomp;
  logic              evt_death;
  logic              evt_win;
  logic              mute;
  sound_pkg::sound_t sound_type;
  logic              clk_8KHZ;
  logic              en;
  logic              clip_start;
  logic              busy;

  modport master (
    output evt_intro, evt_ready, evt_chomp, evt_death, evt_win, mute,
    input  sound_type, clk_8KHZ, en, clip_start, busy
  );

  modport slave (
    input  evt_intro, evt_ready, evt_chomp, evt_death, evt_win, mute,
    output sound_type, clk_8KHZ, en, clip_start, busy
  );
endinterface

// File: rtl/sound_sequencer.sv
// Turns game-event pulses into a timed, prioritised clip selection plus an
// 8 kHz sample strobe for the audio player.
module sound_sequencer #(
  parameter int CLK_DIV       = 3125,
  parameter int CHOMP_SAMPLES = 5735,
  parameter int INTRO_SAMPLES = 12279,
  parameter int DEATH_SAMPLES = 33735,
  parameter int WIN_SAMPLES   = 16000
) (
  input  logic   clk_25MHZ,
  input  logic   rst_n,
  sound_if.slave bus
);
  import sound_pkg::*;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [15:0] CHOMP_LAST = 16'(CHOMP_SAMPLES - 1);
  localparam logic [15:0] INTRO_LAST = 16'(INTRO_SAMPLES - 1);
  localparam logic [15:0] DEATH_LAST = 16'(DEATH_SAMPLES - 1);
  localparam logic [15:0] WIN_LAST   = 16'(WIN_SAMPLES - 1);

  // The sample counter is 16 bits wide; longer clips cannot be timed.
  if (CHOMP_SAMPLES >= 65536 || INTRO_SAMPLES >= 65536 ||
      DEATH_SAMPLES >= 65536 || WIN_SAMPLES >= 65536) begin : g_len_check
    $error("sound_sequencer: clip length parameter must be below 65536");
  end

  typedef enum logic [2:0] {
    ST_IDLE, ST_INTRO, ST_READY, ST_CHOMP, ST_DEATH, ST_WIN
  } state_t;

  state_t           state, state_nxt, req_state;
  logic             req_vld, accept, start_nxt;
  logic [15:0]      samp_cnt, samp_nxt;
  logic [DIV_W-1:0] div_cnt;

  function automatic logic [2:0] prio_of(state_t s);
    case (s)
      ST_DEATH: prio_of = 3'd4;
      ST_WIN:   prio_of = 3'd3;
      ST_INTRO: prio_of = 3'd2;
      ST_READY: prio_of = 3'd1;
      default:  prio_of = 3'd0;
    endcase
  endfunction

  function automatic logic [15:0] last_of(state_t s);
    case (s)
      ST_INTRO: last_of = INTRO_LAST;
      ST_READY: last_of = INTRO_LAST;
      ST_CHOMP: last_of = CHOMP_LAST;
      ST_DEATH: last_of = DEATH_LAST;
      ST_WIN:   last_of = WIN_LAST;
      default:  last_of = 16'd0;
    endcase
  endfunction

  function automatic sound_t sound_of(state_t s);
    case (s)
      ST_INTRO: sound_of = SOUND_LOADING;
      ST_READY: sound_of = SOUND_READY;
      ST_DEATH: sound_of = SOUND_FAIL;
      ST_WIN:   sound_of = SOUND_WIN;
      default:  sound_of = SOUND_GAME_PLAY;
    endcase
  endfunction

  function automatic logic en_of(state_t s);
    case (s)
      ST_INTRO, ST_READY, ST_CHOMP, ST_DEATH: en_of = 1'b1;
      default:                                en_of = 1'b0;
    endcase
  endfunction

  // Free-running strobe divider; events never disturb its phase.
  always_ff @(posedge clk_25MHZ or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt      <= '0;
      bus.clk_8KHZ <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt      <= '0;
      bus.clk_8KHZ <= 1'b1;
    end else begin
      div_cnt      <= div_cnt + DIV_W'(1);
      bus.clk_8KHZ <= 1'b0;
    end
  end

  always_comb begin
    req_vld   = 1'b1;
    req_state = ST_IDLE;
    state_nxt = state;
    samp_nxt  = samp_cnt;
    start_nxt = 1'b0;

    if (bus.evt_death)      req_state = ST_DEATH;
    else if (bus.evt_win)   req_state = ST_WIN;
    else if (bus.evt_intro) req_state = ST_INTRO;
    else if (bus.evt_ready) req_state = ST_READY;
    else if (bus.evt_chomp) req_state = ST_CHOMP;
    else                    req_vld   = 1'b0;

    accept = req_vld && (state == ST_IDLE || prio_of(req_state) >= prio_of(state));

    // A fresh acceptance wins over the end-of-clip return to idle.
    if (accept) begin
      state_nxt = req_state;
      samp_nxt  = 16'd0;
      start_nxt = 1'b1;
    end else if (state != ST_IDLE && bus.clk_8KHZ) begin
      if (samp_cnt == last_of(state)) begin
        state_nxt = ST_IDLE;
        samp_nxt  = 16'd0;
      end else begin
        samp_nxt  = samp_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_25MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      samp_cnt       <= 16'd0;
      bus.sound_type <= SOUND_GAME_PLAY;
      bus.en         <= 1'b0;
      bus.busy       <= 1'b0;
      bus.clip_start <= 1'b0;
    end else begin
      state          <= state_nxt;
      samp_cnt       <= samp_nxt;
      bus.sound_type <= sound_of(state_nxt);
      bus.en         <= en_of(state_nxt) & ~bus.mute;
      bus.busy       <= (state_nxt != ST_IDLE);
      bus.clip_start <= start_nxt;
    end
  end
endmodule

// File: tb/tb_sound_sequencer.sv
// Scenario bench for sound_sequencer with small clip lengths; a negedge
// monitor pops expected clips on clip_start and checks their strobe count.
module tb_sound_sequencer;
  import sound_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int CHOMP   = 3;
  localparam int INTRO   = 5;
  localparam int DEATH   = 6;
  localparam int WIN     = 2;

  logic clk_25MHZ;
  logic rst_n;
  sound_if bus ();

  sound_sequencer #(
    .CLK_DIV      (CLK_DIV),
    .CHOMP_SAMPLES(CHOMP),
    .INTRO_SAMPLES(INTRO),
    .DEATH_SAMPLES(DEATH),
    .WIN_SAMPLES  (WIN)
  ) dut (
    .clk_25MHZ(clk_25MHZ),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  initial clk_25MHZ = 1'b0;
  always #5 clk_25MHZ = ~clk_25MHZ;

  typedef struct {
    sound_t snd;
    logic   en;
    int     len;  // strobes until idle; 0 when the clip is cut short
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cur_len = 0;
  int   s_cnt = 0;
  logic prev_busy = 1'b0;

  // Scoreboard monitor
  always @(negedge clk_25MHZ) begin
    exp_t e;
    if (bus.clip_start === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_clip_start: sound_type %0d with no clip expected", bus.sound_type);
        cur_len = 0;
      end else begin
        e = q.pop_front();
        if (bus.sound_type !== e.snd) begin
          errors++;
          $display("FAIL clip_sound: got %0d want %0d", bus.sound_type, e.snd);
        end
        checks++;
        if (bus.en !== e.en) begin
          errors++;
          $display("FAIL clip_en: got %b want %b", bus.en, e.en);
        end
        cur_len = e.len;
      end
      s_cnt = 0;
    end
    if (bus.busy === 1'b1 && bus.clk_8KHZ === 1'b1) s_cnt++;
    if (prev_busy === 1'b1 && bus.busy === 1'b0 && cur_len > 0) begin
      checks++;
      if (s_cnt != cur_len) begin
        errors++;
        $display("FAIL clip_length: got %0d strobes want %0d", s_cnt, cur_len);
      end
      cur_len = 0;
    end
    prev_busy = bus.busy;
  end

  task automatic push_exp(input sound_t snd, input logic en, input int len);
    exp_t e;
    e.snd = snd;
    e.en  = en;
    e.len = len;
    q.push_back(e);
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (bus.busy !== 1'b0 && n < max_cycles) begin
      @(negedge clk_25MHZ);
      n++;
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy %b after %0d cycles, want 0", bus.busy, n);
    end
    checks++;
    if (bus.en !== 1'b0) begin
      errors++;
      $display("FAIL idle_en: got %b want 0", bus.en);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (bus.sound_type !== SOUND_GAME_PLAY || bus.en !== 1'b0 || bus.busy !== 1'b0 ||
        bus.clip_start !== 1'b0 || bus.clk_8KHZ !== 1'b0) begin
      errors++;
      $display("FAIL %s: snd %0d en %b busy %b start %b strobe %b want 0 0 0 0 0",
               tag, bus.sound_type, bus.en, bus.busy, bus.clip_start, bus.clk_8KHZ);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (10) @(negedge clk_25MHZ);
    check_reset_outputs("reset_values");
    rst_n = 1'b1;
    for (int i = 1; i <= 3 * CLK_DIV; i++) begin
      @(negedge clk_25MHZ);
      checks++;
      if (bus.clk_8KHZ !== ((i % CLK_DIV) == 0)) begin
        errors++;
        $display("FAIL strobe_phase cycle %0d: got %b want %b", i, bus.clk_8KHZ, (i % CLK_DIV) == 0);
      end
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.en !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: busy %b en %b want 0 0", bus.busy, bus.en);
    end
  endtask

  task automatic test_single_chomp();
    push_exp(SOUND_GAME_PLAY, 1'b1, CHOMP);
    @(negedge clk_25MHZ) bus.evt_chomp = 1'b1;
    @(negedge clk_25MHZ) bus.evt_chomp = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.en !== 1'b1 || bus.clip_start !== 1'b1) begin
      errors++;
      $display("FAIL chomp_start: busy %b en %b start %b want 1 1 1", bus.busy, bus.en, bus.clip_start);
    end
    @(negedge clk_25MHZ);
    checks++;
    if (bus.clip_start !== 1'b0) begin
      errors++;
      $display("FAIL chomp_start_width: got %b want 0", bus.clip_start);
    end
    wait_idle(200);
  endtask

  task automatic test_win();
    push_exp(SOUND_WIN, 1'b0, WIN);
    @(negedge clk_25MHZ) bus.evt_win = 1'b1;
    @(negedge clk_25MHZ) bus.evt_win = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.en !== 1'b0) begin
      errors++;
      $display("FAIL win_hold: busy %b en %b want 1 0", bus.busy, bus.en);
    end
    wait_idle(200);
  endtask

  task automatic test_preempt();
    push_exp(SOUND_LOADING, 1'b1, 0);
    @(negedge clk_25MHZ) bus.evt_intro = 1'b1;
    @(negedge clk_25MHZ) bus.evt_intro = 1'b0;
    repeat (2) @(negedge clk_25MHZ);
    push_exp(SOUND_FAIL, 1'b1, DEATH);
    bus.evt_death = 1'b1;
    @(negedge clk_25MHZ) bus.evt_death = 1'b0;
    checks++;
    if (bus.sound_type !== SOUND_FAIL || bus.clip_start !== 1'b1) begin
      errors++;
      $display("FAIL preempt_death: snd %0d start %b want %0d 1", bus.sound_type, bus.clip_start, SOUND_FAIL);
    end
    @(negedge clk_25MHZ) bus.evt_chomp = 1'b1;
    @(negedge clk_25MHZ) bus.evt_chomp = 1'b0;
    checks++;
    if (bus.sound_type !== SOUND_FAIL || bus.clip_start !== 1'b0) begin
      errors++;
      $display("FAIL chomp_dropped: snd %0d start %b want %0d 0", bus.sound_type, bus.clip_start, SOUND_FAIL);
    end
    wait_idle(200);
  endtask

  task automatic test_simultaneous();
    int cnt = 0;
    int n = 0;
    push_exp(SOUND_READY, 1'b1, INTRO);
    @(negedge clk_25MHZ);
    bus.evt_chomp = 1'b1;
    bus.evt_ready = 1'b1;
    @(negedge clk_25MHZ);
    bus.evt_chomp = 1'b0;
    bus.evt_ready = 1'b0;
    checks++;
    if (bus.sound_type !== SOUND_READY) begin
      errors++;
      $display("FAIL same_cycle_prio: got %0d want %0d", bus.sound_type, SOUND_READY);
    end
    wait_idle(200);

    // Restart a chomp exactly on its final strobe
    push_exp(SOUND_GAME_PLAY, 1'b1, 0);
    @(negedge clk_25MHZ) bus.evt_chomp = 1'b1;
    @(negedge clk_25MHZ) bus.evt_chomp = 1'b0;
    while (n < 100) begin
      if (bus.busy === 1'b1 && bus.clk_8KHZ === 1'b1) cnt++;
      if (cnt == CHOMP) break;
      @(negedge clk_25MHZ);
      n++;
    end
    checks++;
    if (cnt != CHOMP) begin
      errors++;
      $display("FAIL restart_reach_end: got %0d strobes want %0d", cnt, CHOMP);
    end
    push_exp(SOUND_GAME_PLAY, 1'b1, CHOMP);
    bus.evt_chomp = 1'b1;
    @(negedge clk_25MHZ) bus.evt_chomp = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.clip_start !== 1'b1 || dut.samp_cnt !== 16'd0) begin
      errors++;
      $display("FAIL restart_chomp: busy %b start %b samp %0d want 1 1 0", bus.busy, bus.clip_start, dut.samp_cnt);
    end
    wait_idle(200);
  endtask

  task automatic test_mute();
    push_exp(SOUND_FAIL, 1'b0, DEATH);
    @(negedge clk_25MHZ);
    bus.mute      = 1'b1;
    bus.evt_death = 1'b1;
    @(negedge clk_25MHZ) bus.evt_death = 1'b0;
    repeat (5) @(negedge clk_25MHZ);
    checks++;
    if (bus.en !== 1'b0 || bus.sound_type !== SOUND_FAIL || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL muted_death: en %b snd %0d busy %b want 0 %0d 1", bus.en, bus.sound_type, bus.busy, SOUND_FAIL);
    end
    bus.mute = 1'b0;
    @(negedge clk_25MHZ);
    checks++;
    if (bus.en !== 1'b1) begin
      errors++;
      $display("FAIL unmute_en: got %b want 1", bus.en);
    end
    wait_idle(200);
  endtask

  task automatic test_reset_mid_clip();
    push_exp(SOUND_FAIL, 1'b1, 0);
    @(negedge clk_25MHZ) bus.evt_death = 1'b1;
    @(negedge clk_25MHZ) bus.evt_death = 1'b0;
    repeat (3) @(negedge clk_25MHZ);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset_mid_clip");
    checks++;
    if (dut.samp_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_samp_cnt: got %0d want 0", dut.samp_cnt);
    end
    @(negedge clk_25MHZ) rst_n = 1'b1;
    repeat (2) @(negedge clk_25MHZ);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.evt_intro = 1'b0;
    bus.evt_ready = 1'b0;
    bus.evt_chomp = 1'b0;
    bus.evt_death = 1'b0;
    bus.evt_win   = 1'b0;
    bus.mute      = 1'b0;

    test_reset();
    test_single_chomp();
    test_win();
    test_preempt();
    test_simultaneous();
    test_mute();
    test_reset_mid_clip();

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d clips never started, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
